// File: rtl/counter_rr_arbiter.sv
// Round-robin sequencer that shares one saturating up/down counter among N_REQ requesters.
// One command every three cycles (IDLE -> ISSUE -> RESP); the post-op value is returned with DONE.
module counter_rr_arbiter #(
   parameter int N_REQ    = 4,
   parameter int WIDTH    = 5,
   parameter bit RST_LOAD = 1'b1
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [N_REQ-1:0]         REQ,
   input  logic [2*N_REQ-1:0]       OP,
   input  logic [WIDTH*N_REQ-1:0]   DATA,
   output logic [N_REQ-1:0]         GNT,
   output logic [N_REQ-1:0]         DONE,
   output logic [WIDTH-1:0]         RESULT,
   output logic                     SAT,
   output logic                     BUSY,
   output logic                     CNT_LOAD,
   output logic                     CNT_UP,
   output logic                     CNT_DOWN,
   output logic [WIDTH-1:0]         CNT_IN,
   input  logic [WIDTH-1:0]         CNT_VAL,
   input  logic                     CNT_HIGH,
   input  logic                     CNT_LOW
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   localparam logic [1:0] OP_UP   = 2'b00;
   localparam logic [1:0] OP_DOWN = 2'b01;
   localparam logic [1:0] OP_LOAD = 2'b10;

   localparam logic [N_REQ-1:0] ONE_N   = N_REQ'(1);
   localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
   localparam logic [IDX_W-1:0] ONE_IDX = IDX_W'(1);
   localparam logic [IDX_W-1:0] LAST    = IDX_W'(N_REQ - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [IDX_W-1:0] ptr, ptr_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic [IDX_W-1:0] pick;
   logic             found;
   logic [IDX_W:0]   cand;
   logic [1:0]       op_q, op_nxt, sel_op;
   logic [WIDTH-1:0] data_q, data_nxt, sel_data;
   logic [N_REQ-1:0] gnt_nxt, done_nxt;
   logic [WIDTH-1:0] result_nxt, in_nxt;
   logic             sat_nxt, busy_nxt, load_nxt, up_nxt, down_nxt;

   assign sel_op   = OP[2*int'(pick) +: 2];
   assign sel_data = DATA[WIDTH*int'(pick) +: WIDTH];

   // Round-robin search: first set request at ptr, ptr+1, ... wrapping at N_REQ.
   always_comb begin
      found = 1'b0;
      pick  = ptr;
      cand  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand  = {1'b0, ptr} + (IDX_W+1)'(k);
         cand  = (cand >= (IDX_W+1)'(N_REQ)) ? (cand - (IDX_W+1)'(N_REQ)) : cand;
         pick  = (!found && REQ[cand[IDX_W-1:0]]) ? cand[IDX_W-1:0] : pick;
         found = found | REQ[cand[IDX_W-1:0]];
      end
   end

   // Next-state and next-output logic for the sequencer.
   always_comb begin
      state_nxt  = state;
      ptr_nxt    = ptr;
      idx_nxt    = idx;
      op_nxt     = op_q;
      data_nxt   = data_q;
      gnt_nxt    = '0;
      done_nxt   = '0;
      result_nxt = RESULT;
      sat_nxt    = SAT;
      busy_nxt   = 1'b0;
      load_nxt   = 1'b0;
      up_nxt     = 1'b0;
      down_nxt   = 1'b0;
      in_nxt     = '0;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = ISSUE;
               idx_nxt   = pick;
               op_nxt    = sel_op;
               data_nxt  = sel_data;
               gnt_nxt   = ONE_N << pick;
               busy_nxt  = 1'b1;
               case (sel_op)
                  OP_UP:   up_nxt = 1'b1;
                  OP_DOWN: down_nxt = 1'b1;
                  OP_LOAD: begin
                     load_nxt = 1'b1;
                     in_nxt   = sel_data;
                  end
                  default: load_nxt = 1'b0;
               endcase
            end else begin
               state_nxt = IDLE;
            end
         end
         ISSUE: begin
            // RESULT is registered, so the post-op value is derived from the pre-op sample.
            state_nxt = RESP;
            busy_nxt  = 1'b1;
            done_nxt  = ONE_N << idx;
            ptr_nxt   = (idx == LAST) ? '0 : (idx + ONE_IDX);
            case (op_q)
               OP_UP: begin
                  sat_nxt    = CNT_HIGH;
                  result_nxt = CNT_HIGH ? CNT_VAL : (CNT_VAL + ONE_W);
               end
               OP_DOWN: begin
                  sat_nxt    = CNT_LOW;
                  result_nxt = CNT_LOW ? CNT_VAL : (CNT_VAL - ONE_W);
               end
               OP_LOAD: begin
                  sat_nxt    = 1'b0;
                  result_nxt = data_q;
               end
               default: begin
                  sat_nxt    = 1'b0;
                  result_nxt = CNT_VAL;
               end
            endcase
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Latched command and registered outputs; reset also loads the counter when enabled.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr      <= '0;
         idx      <= '0;
         op_q     <= OP_UP;
         data_q   <= '0;
         GNT      <= '0;
         DONE     <= '0;
         RESULT   <= '0;
         SAT      <= 1'b0;
         BUSY     <= 1'b0;
         CNT_LOAD <= RST_LOAD;
         CNT_UP   <= 1'b0;
         CNT_DOWN <= 1'b0;
         CNT_IN   <= '0;
      end else begin
         ptr      <= ptr_nxt;
         idx      <= idx_nxt;
         op_q     <= op_nxt;
         data_q   <= data_nxt;
         GNT      <= gnt_nxt;
         DONE     <= done_nxt;
         RESULT   <= result_nxt;
         SAT      <= sat_nxt;
         BUSY     <= busy_nxt;
         CNT_LOAD <= load_nxt;
         CNT_UP   <= up_nxt;
         CNT_DOWN <= down_nxt;
         CNT_IN   <= in_nxt;
      end
   end

endmodule

// File: tb/tb_counter_rr_arbiter.sv
// Self-checking bench for counter_rr_arbiter with a behavioural saturating counter attached.
// Expected DONE/RESULT/SAT go into a scoreboard when a request is driven and are popped on DONE.
module tb_counter_rr_arbiter;

   localparam int N = 4;
   localparam int W = 5;

   localparam logic [1:0] UP   = 2'b00;
   localparam logic [1:0] DOWN = 2'b01;
   localparam logic [1:0] LOAD = 2'b10;
   localparam logic [1:0] READ = 2'b11;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [2*N-1:0] op_bus;
   logic [W*N-1:0] data_bus;
   logic [N-1:0]   gnt, done;
   logic [W-1:0]   result, cnt_in, cnt;
   logic           sat, busy, cnt_load, cnt_up, cnt_down, cnt_high, cnt_low;

   typedef struct {
      int           idx;
      logic [W-1:0] res;
      logic         sat;
   } exp_t;

   exp_t         sb[$];
   int           n_checks = 0;
   int           n_fail = 0;
   logic         mon_en = 1'b0;
   logic         rst_q = 1'b0;
   logic [N-1:0] prev_gnt = '0;

   always #5 clk = ~clk;

   counter_rr_arbiter #(.N_REQ(N), .WIDTH(W), .RST_LOAD(1'b1)) dut (
      .CLK(clk), .RST(rst), .REQ(req), .OP(op_bus), .DATA(data_bus),
      .GNT(gnt), .DONE(done), .RESULT(result), .SAT(sat), .BUSY(busy),
      .CNT_LOAD(cnt_load), .CNT_UP(cnt_up), .CNT_DOWN(cnt_down), .CNT_IN(cnt_in),
      .CNT_VAL(cnt), .CNT_HIGH(cnt_high), .CNT_LOW(cnt_low)
   );

   // External 5-bit saturating counter with no reset of its own.
   always @(posedge clk) begin
      if (cnt_load) cnt <= cnt_in;
      else if (cnt_up && cnt != 5'd31) cnt <= cnt + 5'd1;
      else if (cnt_down && cnt != 5'd0) cnt <= cnt - 5'd1;
   end
   assign cnt_high = (cnt == 5'd31);
   assign cnt_low  = (cnt == 5'd0);

   always @(posedge clk) rst_q <= rst;

   // Every-cycle invariants plus scoreboard pop on DONE.
   initial begin : monitor
      exp_t         e;
      logic [N-1:0] exp_done;
      logic [N-1:0] exp_oh;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            n_checks++;
            if (!$onehot0(gnt)) begin
               n_fail++; $display("FAIL gnt_onehot: got %b, required one-hot or zero", gnt);
            end
            n_checks++;
            if (cnt_up && cnt_down) begin
               n_fail++; $display("FAIL up_down_excl: got up=%b down=%b, required not both", cnt_up, cnt_down);
            end
            exp_done = rst_q ? 4'b0000 : prev_gnt;
            n_checks++;
            if (done !== exp_done) begin
               n_fail++; $display("FAIL done_follows_gnt: got %b, required %b", done, exp_done);
            end
            if (done !== 4'b0000) begin
               n_checks++;
               if (sb.size() == 0) begin
                  n_fail++; $display("FAIL unexpected_done: got %b, required no DONE", done);
               end else begin
                  e = sb.pop_front();
                  exp_oh = 4'b0001 << e.idx;
                  n_checks++;
                  if (done !== exp_oh) begin
                     n_fail++; $display("FAIL done_idx: got %b, required %b", done, exp_oh);
                  end
                  n_checks++;
                  if (result !== e.res) begin
                     n_fail++; $display("FAIL result: got %0d, required %0d", result, e.res);
                  end
                  n_checks++;
                  if (sat !== e.sat) begin
                     n_fail++; $display("FAIL sat: got %b, required %b", sat, e.sat);
                  end
               end
            end
            prev_gnt = gnt;
         end
      end
   end

   // One complete command from requester i, starting and ending on a negedge in IDLE.
   task automatic run_op(input int i, input logic [1:0] op, input logic [W-1:0] d,
                         input logic [W-1:0] exp_res, input logic exp_sat);
      logic [N-1:0] exp_gnt;
      logic [2:0]   exp_ctl;
      logic [W-1:0] exp_in;
      exp_gnt = 4'b0001 << i;
      case (op)
         UP:      exp_ctl = 3'b010;
         DOWN:    exp_ctl = 3'b001;
         LOAD:    exp_ctl = 3'b100;
         default: exp_ctl = 3'b000;
      endcase
      exp_in = (op == LOAD) ? d : 5'd0;
      op_bus[2*i +: 2] = op;
      data_bus[W*i +: W] = d;
      req[i] = 1'b1;
      sb.push_back('{idx: i, res: exp_res, sat: exp_sat});
      @(negedge clk);
      req[i] = 1'b0;
      n_checks++;
      if (gnt !== exp_gnt) begin
         n_fail++; $display("FAIL gnt: got %b, required %b", gnt, exp_gnt);
      end
      n_checks++;
      if ({cnt_load, cnt_up, cnt_down} !== exp_ctl) begin
         n_fail++; $display("FAIL issue_ctl: got %b, required %b", {cnt_load, cnt_up, cnt_down}, exp_ctl);
      end
      n_checks++;
      if (cnt_in !== exp_in) begin
         n_fail++; $display("FAIL cnt_in: got %0d, required %0d", cnt_in, exp_in);
      end
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL busy_issue: got %b, required 1", busy);
      end
      @(negedge clk);
      n_checks++;
      if ({cnt_load, cnt_up, cnt_down, busy} !== 4'b0001) begin
         n_fail++; $display("FAIL resp_ctl: got %b, required 0001", {cnt_load, cnt_up, cnt_down, busy});
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL busy_idle: got %b, required 0", busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = '0;
      op_bus = '0;
      data_bus = '0;
      @(negedge clk);
      n_checks++;
      if ({cnt_load, cnt_in} !== {1'b1, 5'd0}) begin
         n_fail++; $display("FAIL rst_load: got load=%b in=%0d, required load=1 in=0", cnt_load, cnt_in);
      end
      n_checks++;
      if ({gnt, done, busy, cnt_up, cnt_down} !== 11'd0) begin
         n_fail++; $display("FAIL rst_ctl: got %b, required 0", {gnt, done, busy, cnt_up, cnt_down});
      end
      n_checks++;
      if ({result, sat} !== 6'd0) begin
         n_fail++; $display("FAIL rst_result: got %0d/%b, required 0/0", result, sat);
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (cnt_load !== 1'b0) begin
         n_fail++; $display("FAIL rst_load_clear: got %b, required 0", cnt_load);
      end
      n_checks++;
      if (cnt !== 5'd0) begin
         n_fail++; $display("FAIL rst_cnt_val: got %0d, required 0", cnt);
      end
      mon_en = 1'b1;
   endtask

   task automatic test_load();
      run_op(0, LOAD, 5'd5, 5'd5, 1'b0);
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp_gnt;
      run_op(3, LOAD, 5'd0, 5'd0, 1'b0);
      op_bus = {UP, UP, UP, UP};
      req = 4'b1111;
      for (int g = 0; g < 5; g++) sb.push_back('{idx: g % N, res: 5'(g + 1), sat: 1'b0});
      for (int g = 0; g < 5; g++) begin
         exp_gnt = 4'b0001 << (g % N);
         @(negedge clk);
         n_checks++;
         if (gnt !== exp_gnt) begin
            n_fail++; $display("FAIL rr_gnt%0d: got %b, required %b", g, gnt, exp_gnt);
         end
         n_checks++;
         if (cnt_up !== 1'b1) begin
            n_fail++; $display("FAIL rr_up%0d: got %b, required 1", g, cnt_up);
         end
         if (g == 4) req = 4'b0000;
         @(negedge clk);
         @(negedge clk);
      end
   endtask

   task automatic test_saturation();
      run_op(1, LOAD, 5'd31, 5'd31, 1'b0);
      run_op(2, UP,   5'd0,  5'd31, 1'b1);
      run_op(3, LOAD, 5'd0,  5'd0,  1'b0);
      run_op(0, DOWN, 5'd0,  5'd0,  1'b1);
      run_op(1, LOAD, 5'd17, 5'd17, 1'b0);
      run_op(2, READ, 5'd9,  5'd17, 1'b0);
      run_op(3, DOWN, 5'd0,  5'd16, 1'b0);
   endtask

   task automatic test_mid_reset();
      run_op(0, READ, 5'd0, 5'd16, 1'b0);
      op_bus[5:4] = UP;
      req = 4'b0100;
      @(negedge clk);
      n_checks++;
      if (gnt !== 4'b0100) begin
         n_fail++; $display("FAIL mid_gnt: got %b, required 0100", gnt);
      end
      req = 4'b0000;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if ({gnt, done, busy, cnt_up, cnt_down, sat} !== 12'd0) begin
         n_fail++; $display("FAIL mid_rst_ctl: got %b, required 0", {gnt, done, busy, cnt_up, cnt_down, sat});
      end
      n_checks++;
      if ({cnt_load, cnt_in, result} !== {1'b1, 10'd0}) begin
         n_fail++; $display("FAIL mid_rst_load: got load=%b in=%0d res=%0d, required 1/0/0", cnt_load, cnt_in, result);
      end
      @(negedge clk);
      n_checks++;
      if (cnt !== 5'd0) begin
         n_fail++; $display("FAIL mid_reload: got %0d, required 0", cnt);
      end
      op_bus = {READ, READ, READ, READ};
      req = 4'b1111;
      sb.push_back('{idx: 0, res: 5'd0, sat: 1'b0});
      @(negedge clk);
      n_checks++;
      if (gnt !== 4'b0001) begin
         n_fail++; $display("FAIL mid_ptr_reset: got %b, required 0001", gnt);
      end
      req = 4'b0000;
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_load();
      test_round_robin();
      test_saturation();
      test_mid_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++; $display("FAIL sb_drained: got %0d pending, required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
